thread_fetch_sched: RTL and testbench
=====================================

Name: thread_fetch_sched

Overview:
Per-thread fetch scheduler for the multithreaded core. It holds one PC per hardware thread and round-robin arbitrates the single fetch port among ready threads. A thread is parked once decode flags a branch/JAL/JALR. The parked thread is redirected when the branch unit resolves that branch: this block pops the branch-result FIFO head via pc_ack and loads pc_n. A squash pulse tells downstream to drop that thread's in-flight wrong-path fetches.

Parameters:
THREAD_WIDTH, 2, thread-ID width; NUM_THREADS = 1<<THREAD_WIDTH
XLEN, 32, PC width
RESET_PC, 32'h0000_0000, PC loaded into every thread at reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall_i  in  1  global pipeline stall; freezes all state
thread_en  in  NUM_THREADS  per-thread run enable
fetch_ready  in  1  fetch port accepts a request this cycle
fetch_valid  out  1  fetch request valid
fetch_pc  out  XLEN  PC of request
fetch_thread_id  out  THREAD_WIDTH  thread of request
dec_br_valid  in  1  decode saw a control-flow instruction
dec_br_thread_id  in  THREAD_WIDTH  its thread
br_valid  in  1  branch FIFO head resolved (head valid bit)
br_empty  in  1  branch FIFO empty
br_true  in  1  head branch taken (informational; feeds taken counter)
br_thread_id  in  THREAD_WIDTH  head thread
br_pc_n  in  XLEN  head next PC (target or fall-through)
pc_ack  out  1  pop branch FIFO head
squash_valid  out  1  drop in-flight fetches of squash_thread_id
squash_thread_id  out  THREAD_WIDTH  thread being redirected
thread_state  out  2*NUM_THREADS  packed per-thread state, for debug and bench
err_stray_br  out  1  sticky: resolution arrived for a thread not in BR_WAIT

Behaviour:
- Reset (rst=1 at posedge):
  - all threads IDLE, all PCs = RESET_PC, RR pointer = NUM_THREADS-1, err_stray_br = 0.
  - Combinational outputs are therefore 0 out of reset.
- Per-thread states: IDLE=0, READY=1, BR_WAIT=2.
  - IDLE -> READY: thread_en[t]=1.
  - READY -> IDLE: thread_en[t]=0. A pending grant to that thread is suppressed that cycle.
  - READY -> BR_WAIT: dec_br_valid && dec_br_thread_id==t.
  - BR_WAIT -> READY on pc_ack for thread t, or -> IDLE if thread_en[t]=0 at that point.
  - thread_en drop in BR_WAIT is deferred until the branch resolves.
- Eligible[t]: state==READY, thread_en[t]=1, and not (dec_br_valid && dec_br_thread_id==t). Decode-branch blocks the same-cycle grant.
- Grant:
  - first eligible thread searching from RR+1 upward, mod NUM_THREADS.
  - fetch_valid = any eligible && !stall_i; fetch_pc/fetch_thread_id come from the granted thread, combinationally (0-cycle latency).
- Accept (fetch_valid && fetch_ready): granted PC += 4 (mod 2^XLEN, wraps silently); RR <= granted ID. RR does not move without accept.
- Resolution:
  - pc_ack = br_valid && !br_empty && !stall_i.
  - On pc_ack: PC[br_thread_id] <= br_pc_n; state transition as above; squash_valid=1 and squash_thread_id=br_thread_id, same cycle as pc_ack.
  - If the thread is not in BR_WAIT: set err_stray_br, PC still loaded, state unchanged.
- Simultaneous events:
  - pc_ack for thread A and grant to thread B≠A are both legal in one cycle.
  - A redirected thread becomes eligible the cycle after pc_ack.
  - dec_br for thread X and pc_ack for thread X in the same cycle: pc_ack wins (that dec_br is a squashed wrong-path op), and the thread goes READY.
- stall_i=1: no state, PC or RR update; fetch_valid=0, pc_ack=0, squash_valid=0.
- Mid-operation reset: all threads return to IDLE/RESET_PC regardless of outstanding branches. The branch FIFO is reset by the same rst.

Decomposition:
- Shared package: thread-state enum, fetch_req_t {valid, pc, thread_id}, br_result_t {valid, br_true, thread_id, pc_n}; XLEN and THREAD_WIDTH come from the existing constants header.
- One sub-module, rr_arbiter (NUM_THREADS requests, pointer input, one-hot plus binary grant). Everything else stays in the top module.

Test Plan:
1. Reset, then thread_en=4'b0001, fetch_ready=1 → thread 0 fetches 0x0, 0x4, 0x8 on consecutive cycles; pc_ack=0.
2. thread_en=4'b1111, fetch_ready=1 → thread IDs 0,1,2,3,0, each thread's PC advancing by 4. With fetch_ready=0 for 2 cycles, the same request is held and RR does not move.
3. Thread 1 at PC 0x10, dec_br_valid with thread 1 → thread 1 skipped for 5 cycles. Then br_valid=1, br_empty=0, br_thread_id=1, br_pc_n=0x200 → pc_ack and squash(1) the same cycle; the next grant of thread 1 has fetch_pc=0x200.
4. Same cycle: dec_br for thread 2, thread 2 otherwise the next RR pick → grant goes to thread 3; thread 2 enters BR_WAIT.
5. stall_i=1 for 3 cycles while br_valid=1 → pc_ack=0, fetch_valid=0, PCs frozen. Stall release → pc_ack the next cycle.
6. br_valid for thread 3 while it is READY → err_stray_br=1 and sticky, PC[3]=br_pc_n. Assert rst mid-BR_WAIT → all threads IDLE, PCs=0, err cleared.

Source files
------------

// File: rtl/thread_fetch_sched_pkg.sv
// rtl/thread_fetch_sched_pkg.sv - shared types and constants for the per-thread fetch scheduler
package thread_fetch_sched_pkg;

    localparam int TFS_XLEN         = 32;
    localparam int TFS_THREAD_WIDTH = 2;

    typedef enum logic [1:0] {
        TS_IDLE    = 2'd0,
        TS_READY   = 2'd1,
        TS_BR_WAIT = 2'd2
    } thread_state_e;

    typedef struct packed {
        logic                        valid;
        logic [TFS_XLEN-1:0]         pc;
        logic [TFS_THREAD_WIDTH-1:0] thread_id;
    } fetch_req_t;

    typedef struct packed {
        logic                        valid;
        logic                        br_true;
        logic [TFS_THREAD_WIDTH-1:0] thread_id;
        logic [TFS_XLEN-1:0]         pc_n;
    } br_result_t;

endpackage

// File: rtl/thread_fetch_sched_rr_arbiter.sv
// rtl/thread_fetch_sched_rr_arbiter.sv - round-robin arbiter, search starts one past the pointer
module thread_fetch_sched_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] idx;

    // First requester at ptr+1, ptr+2, ... ptr (N is a power of two so the add wraps)
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_onehot = '0;
        gnt_id     = '0;
        idx        = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ptr + IW'(i);
            if (!gnt_valid && req[idx]) begin
                gnt_valid       = 1'b1;
                gnt_id          = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_fetch_sched.sv
// rtl/thread_fetch_sched.sv - per-thread PC holder with round-robin fetch grant and branch redirect
module thread_fetch_sched
    import thread_fetch_sched_pkg::*;
#(
    parameter int          THREAD_WIDTH = TFS_THREAD_WIDTH,
    parameter int          XLEN         = TFS_XLEN,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_i,
    input  logic [(1<<THREAD_WIDTH)-1:0] thread_en,
    input  logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [XLEN-1:0]              fetch_pc,
    output logic [THREAD_WIDTH-1:0]      fetch_thread_id,
    input  logic                         dec_br_valid,
    input  logic [THREAD_WIDTH-1:0]      dec_br_thread_id,
    input  logic                         br_valid,
    input  logic                         br_empty,
    input  logic                         br_true,
    input  logic [THREAD_WIDTH-1:0]      br_thread_id,
    input  logic [XLEN-1:0]              br_pc_n,
    output logic                         pc_ack,
    output logic                         squash_valid,
    output logic [THREAD_WIDTH-1:0]      squash_thread_id,
    output logic [2*(1<<THREAD_WIDTH)-1:0] thread_state,
    output logic                         err_stray_br
);

    localparam int NUM_THREADS = 1 << THREAD_WIDTH;

    thread_state_e          state_q [NUM_THREADS];
    logic [XLEN-1:0]        pc_q    [NUM_THREADS];
    logic [THREAD_WIDTH-1:0] rr_q;
    logic [15:0]            taken_cnt;

    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] dec_hit;
    logic [NUM_THREADS-1:0] ack_hit;
    logic                   gnt_valid;
    logic [NUM_THREADS-1:0] gnt_onehot;
    logic [THREAD_WIDTH-1:0] gnt_id;
    logic                   accept;
    fetch_req_t             req;
    br_result_t             br;

    assign br.valid     = br_valid && !br_empty;
    assign br.br_true   = br_true;
    assign br.thread_id = br_thread_id;
    assign br.pc_n      = br_pc_n;

    assign pc_ack = br.valid && !stall_i;

    // Per-thread eligibility; a same-cycle decode branch keeps the thread off the fetch port
    always_comb begin
        eligible     = '0;
        dec_hit      = '0;
        ack_hit      = '0;
        thread_state = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            dec_hit[t]  = dec_br_valid && (dec_br_thread_id == THREAD_WIDTH'(t));
            ack_hit[t]  = pc_ack && (br.thread_id == THREAD_WIDTH'(t));
            eligible[t] = (state_q[t] == TS_READY) && thread_en[t] && !dec_hit[t];
            thread_state[2*t +: 2] = state_q[t];
        end
    end

    thread_fetch_sched_rr_arbiter #(
        .N  (NUM_THREADS),
        .IW (THREAD_WIDTH)
    ) u_arb (
        .req        (eligible),
        .ptr        (rr_q),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id)
    );

    // Fetch request is zeroed when not valid so idle outputs read as 0
    always_comb begin
        req.valid     = gnt_valid && !stall_i;
        req.pc        = req.valid ? pc_q[gnt_id] : '0;
        req.thread_id = req.valid ? gnt_id : '0;
    end

    assign fetch_valid      = req.valid;
    assign fetch_pc         = req.pc;
    assign fetch_thread_id  = req.thread_id;
    assign accept           = req.valid && fetch_ready;
    assign squash_valid     = pc_ack;
    assign squash_thread_id = pc_ack ? br.thread_id : '0;

    // Thread state, PCs, RR pointer and sticky error; a stall freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= TS_IDLE;
                pc_q[t]    <= XLEN'(RESET_PC);
            end
            rr_q         <= THREAD_WIDTH'(NUM_THREADS - 1);
            err_stray_br <= 1'b0;
            taken_cnt    <= '0;
        end else if (!stall_i) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                case (state_q[t])
                    TS_IDLE: begin
                        if (thread_en[t]) state_q[t] <= TS_READY;
                    end
                    TS_READY: begin
                        // A resolution for this thread beats its decode branch (wrong-path op)
                        if (!thread_en[t])                  state_q[t] <= TS_IDLE;
                        else if (dec_hit[t] && !ack_hit[t]) state_q[t] <= TS_BR_WAIT;
                    end
                    TS_BR_WAIT: begin
                        // Disable is held off until the outstanding branch resolves
                        if (ack_hit[t]) state_q[t] <= thread_en[t] ? TS_READY : TS_IDLE;
                    end
                    default: state_q[t] <= TS_IDLE;
                endcase
                if (ack_hit[t])
                    pc_q[t] <= br.pc_n;
                else if (accept && gnt_onehot[t])
                    pc_q[t] <= pc_q[t] + XLEN'(4);
            end
            if (accept)
                rr_q <= gnt_id;
            if (pc_ack && (state_q[br.thread_id] != TS_BR_WAIT))
                err_stray_br <= 1'b1;
            if (pc_ack && br.br_true)
                taken_cnt <= taken_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_thread_fetch_sched.sv
// tb/tb_thread_fetch_sched.sv - directed vector bench for thread_fetch_sched
module tb_thread_fetch_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic [3:0]  thread_en;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_thread_id;
    logic        dec_br_valid;
    logic [1:0]  dec_br_thread_id;
    logic        br_valid;
    logic        br_empty;
    logic        br_true;
    logic [1:0]  br_thread_id;
    logic [31:0] br_pc_n;
    logic        pc_ack;
    logic        squash_valid;
    logic [1:0]  squash_thread_id;
    logic [7:0]  thread_state;
    logic        err_stray_br;

    always #5 clk = ~clk;

    thread_fetch_sched dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .thread_en        (thread_en),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_thread_id  (fetch_thread_id),
        .dec_br_valid     (dec_br_valid),
        .dec_br_thread_id (dec_br_thread_id),
        .br_valid         (br_valid),
        .br_empty         (br_empty),
        .br_true          (br_true),
        .br_thread_id     (br_thread_id),
        .br_pc_n          (br_pc_n),
        .pc_ack           (pc_ack),
        .squash_valid     (squash_valid),
        .squash_thread_id (squash_thread_id),
        .thread_state     (thread_state),
        .err_stray_br     (err_stray_br)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic        rdy;
        logic        stall;
        logic        dv;
        logic [1:0]  dt;
        logic        bv;
        logic        be;
        logic [1:0]  bt;
        logic [31:0] bpc;
        logic        efv;
        logic [31:0] epc;
        logic [1:0]  etid;
        logic        eack;
        logic        eerr;
        logic [7:0]  est;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   row      = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] en, input logic rdy, input logic st,
                                input logic dv, input logic [1:0] dt, input logic bv, input logic be,
                                input logic [1:0] bt, input logic [31:0] bpc, input logic efv,
                                input logic [31:0] epc, input logic [1:0] etid, input logic eack,
                                input logic eerr, input logic [7:0] est);
        vec_t v;
        v.rst = r; v.en = en; v.rdy = rdy; v.stall = st; v.dv = dv; v.dt = dt;
        v.bv = bv; v.be = be; v.bt = bt; v.bpc = bpc; v.efv = efv; v.epc = epc;
        v.etid = etid; v.eack = eack; v.eerr = eerr; v.est = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare at the falling edge, then step past the rising edge
    task automatic run_vec(input vec_t v);
        rst = v.rst; thread_en = v.en; fetch_ready = v.rdy; stall_i = v.stall;
        dec_br_valid = v.dv; dec_br_thread_id = v.dt;
        br_valid = v.bv; br_empty = v.be; br_thread_id = v.bt; br_pc_n = v.bpc;
        @(negedge clk);
        chk("fetch_valid",      {31'd0, fetch_valid},      {31'd0, v.efv});
        chk("fetch_pc",         fetch_pc,                  v.epc);
        chk("fetch_thread_id",  {30'd0, fetch_thread_id},  {30'd0, v.etid});
        chk("pc_ack",           {31'd0, pc_ack},           {31'd0, v.eack});
        chk("squash_valid",     {31'd0, squash_valid},     {31'd0, v.eack});
        chk("squash_thread_id", {30'd0, squash_thread_id}, {30'd0, (v.eack ? v.bt : 2'd0)});
        chk("err_stray_br",     {31'd0, err_stray_br},     {31'd0, v.eerr});
        chk("thread_state",     {24'd0, thread_state},     {24'd0, v.est});
        @(posedge clk);
        #1;
        row++;
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; thread_en = 4'b0; fetch_ready = 1'b0;
        dec_br_valid = 1'b0; dec_br_thread_id = 2'd0; br_valid = 1'b0; br_empty = 1'b1;
        br_true = 1'b0; br_thread_id = 2'd0; br_pc_n = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        //                 rst en     rdy st dv dt bv be bt bpc            fv pc            tid ack err st
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h0,        0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h4,        0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h8,        0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'hC,        0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h0,        1, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h0,        2, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h0,        3, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h10,       0, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h4,        1, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h4,        2, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h4,        3, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h14,       0, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h8,        1, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h8,        2, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h8,        3, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h18,       0, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'hC,        1, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 1, 1, 0, 1, 0, 32'h0,         1, 32'hC,        2, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'hC,        3, 0, 0, 8'h59));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h1C,       0, 0, 0, 8'h59));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h10,       2, 0, 0, 8'h59));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h10,       3, 0, 0, 8'h59));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h20,       0, 0, 0, 8'h59));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 1, 0, 1, 32'h200,       1, 32'h14,       2, 1, 0, 8'h59));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h14,       3, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h24,       0, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h200,      1, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 1, 2, 0, 1, 0, 32'h0,         1, 32'h18,       3, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 0, 0, 1, 0, 2, 32'h300,       0, 32'h0,        0, 0, 0, 8'h65));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 0, 0, 1, 0, 2, 32'h300,       0, 32'h0,        0, 0, 0, 8'h65));
        tbl.push_back(mk(0, 4'b1111, 1, 1, 0, 0, 1, 0, 2, 32'h300,       0, 32'h0,        0, 0, 0, 8'h65));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 1, 0, 2, 32'h300,       1, 32'h28,       0, 1, 0, 8'h65));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h204,      1, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h300,      2, 0, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 1, 0, 3, 32'h400,       1, 32'h1C,       3, 1, 0, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h2C,       0, 0, 1, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h208,      1, 0, 1, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 1, 1, 0, 32'h999,       1, 32'h304,      2, 0, 1, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h400,      3, 0, 1, 8'h55));
        tbl.push_back(mk(0, 4'b1111, 1, 0, 1, 0, 0, 1, 0, 32'h0,         1, 32'h20C,      1, 0, 1, 8'h55));
        tbl.push_back(mk(1, 4'b1111, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h308,      2, 0, 1, 8'h56));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h0,        0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 0, 8'h01));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 0, 8'h00));

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i]);

        // PC wrap after a stray redirect into an IDLE thread
        run_vec(mk(1, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 0, 8'h00));
        run_vec(mk(0, 4'b0000, 1, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 32'h0,        0, 1, 0, 8'h00));
        run_vec(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 1, 8'h00));
        run_vec(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 1, 8'h01));
        run_vec(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h0,        0, 0, 1, 8'h01));

        // Disable while in BR_WAIT is deferred until the resolution, which then parks the thread IDLE
        run_vec(mk(0, 4'b0001, 1, 0, 1, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 1, 8'h01));
        run_vec(mk(0, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 1, 8'h02));
        run_vec(mk(0, 4'b0000, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 1, 8'h02));
        run_vec(mk(0, 4'b0000, 1, 0, 0, 0, 1, 0, 0, 32'h80,        0, 32'h0,        0, 1, 1, 8'h02));
        run_vec(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0, 32'h0,        0, 0, 1, 8'h00));

        // Decode branch and resolution for the same thread in one cycle: resolution wins, stays READY
        run_vec(mk(0, 4'b0001, 1, 0, 1, 0, 1, 0, 0, 32'h500,       0, 32'h0,        0, 1, 1, 8'h01));
        run_vec(mk(0, 4'b0001, 1, 0, 0, 0, 0, 1, 0, 32'h0,         1, 32'h500,      0, 0, 1, 8'h01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
